tx_frame_ctrl: RTL and testbench

Transmit framing controller sitting directly upstream of the physical-layer byte mux. It drives the mux select (`control`) and the K-symbol inputs (`start_end`, `ordered_set`, `logical_COM`), and pops the transmit data buffer whose head byte feeds the mux data input. It frames each buffered packet as STP, data, END, and inserts periodic SKP ordered sets and on-request FTS ordered sets. When there is nothing to send, it fills the link with IDL.

---
 rtl/tx_symbols_pkg.sv | 34 +++
 rtl/skp_timer.sv | 37 +++
 rtl/tx_frame_ctrl.sv | 135 +++++++++++++
 tb/tb_tx_frame_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_symbols_pkg.sv
// rtl/tx_symbols_pkg.sv - symbol constants, mux selects and state types for transmit framing
package tx_symbols_pkg;

  // K-symbol byte values presented to the physical-layer byte mux
  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_IDL = 8'h7C;
  localparam logic [7:0] SYM_FTS = 8'h3C;
  localparam logic [7:0] SYM_COM = 8'hBC;

  // Mux select encodings
  localparam logic [1:0] CTL_DATA = 2'b00;
  localparam logic [1:0] CTL_SE   = 2'b01;
  localparam logic [1:0] CTL_OS   = 2'b10;
  localparam logic [1:0] CTL_COM  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_OS_COM    = 3'd1,
    ST_OS_BODY   = 3'd2,
    ST_PKT_START = 3'd3,
    ST_PKT_DATA  = 3'd4,
    ST_PKT_END   = 3'd5
  } tx_state_e;

  typedef enum logic {
    OS_KIND_SKP = 1'b0,
    OS_KIND_FTS = 1'b1
  } os_kind_e;

endpackage

// File: rtl/skp_timer.sv
// rtl/skp_timer.sv - free-running SKP interval counter with pending-request flag
module skp_timer #(
  parameter int unsigned SKP_INTERVAL = 1180
) (
  input  logic clk,
  input  logic reset_L,
  input  logic skp_clr,
  output logic skp_pending
);

  localparam int unsigned CW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          wrap;

  // Wrap at the end of each interval; a wrap coinciding with a clear re-arms the flag
  always_comb begin
    wrap   = (cnt_q == CW'(SKP_INTERVAL - 1));
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    pend_d = (pend_q & ~skp_clr) | wrap;
  end

  // Counter and pending flag registers
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign skp_pending = pend_q;

endmodule

// File: rtl/tx_frame_ctrl.sv
// rtl/tx_frame_ctrl.sv - frames buffered packets and inserts SKP/FTS ordered sets ahead of the byte mux
module tx_frame_ctrl
  import tx_symbols_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned N_SKP        = 3,
  parameter int unsigned N_FTS        = 4
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       fifo_empty,
  input  logic       fifo_last,
  input  logic       fts_req,
  output logic       fifo_rd,
  output logic [1:0] control,
  output logic [7:0] start_end,
  output logic [7:0] ordered_set,
  output logic [7:0] logical_COM,
  output logic       underrun,
  output logic       pkt_done
);

  tx_state_e state_q, state_d;
  os_kind_e  kind_q, kind_d;
  logic [7:0] os_cnt_q, os_cnt_d;
  logic       fts_pend_q, fts_pend_d;
  logic       skp_pending;
  logic       skp_clr, fts_clr;
  logic       take_arb;
  tx_state_e  arb_state;
  os_kind_e   arb_kind;

  skp_timer #(
    .SKP_INTERVAL(SKP_INTERVAL)
  ) u_skp_timer (
    .clk        (clk),
    .reset_L    (reset_L),
    .skp_clr    (skp_clr),
    .skp_pending(skp_pending)
  );

  // State, ordered-set kind, body counter and FTS request registers
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q    <= ST_IDLE;
      kind_q     <= OS_KIND_SKP;
      os_cnt_q   <= '0;
      fts_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      os_cnt_q   <= os_cnt_d;
      fts_pend_q <= fts_pend_d;
    end
  end

  // Next state: arbitration only at packet/ordered-set boundaries, SKP before FTS before data
  always_comb begin
    arb_state = ST_IDLE;
    arb_kind  = OS_KIND_SKP;
    if (skp_pending) begin
      arb_state = ST_OS_COM;
    end else if (fts_pend_q) begin
      arb_state = ST_OS_COM;
      arb_kind  = OS_KIND_FTS;
    end else if (!fifo_empty) begin
      arb_state = ST_PKT_START;
    end

    state_d  = state_q;
    kind_d   = kind_q;
    os_cnt_d = os_cnt_q;
    take_arb = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_PKT_END: take_arb = 1'b1;
      ST_OS_COM: begin
        state_d  = ST_OS_BODY;
        os_cnt_d = (kind_q == OS_KIND_FTS) ? 8'(N_FTS - 1) : 8'(N_SKP - 1);
      end
      ST_OS_BODY: begin
        if (os_cnt_q == '0) take_arb = 1'b1;
        else                os_cnt_d = os_cnt_q - 8'd1;
      end
      ST_PKT_START: state_d = ST_PKT_DATA;
      ST_PKT_DATA: begin
        if (fifo_empty)     state_d = ST_IDLE;
        else if (fifo_last) state_d = ST_PKT_END;
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_arb) begin
      state_d = arb_state;
      if (arb_state == ST_OS_COM) kind_d = arb_kind;
    end

    skp_clr    = take_arb && (arb_state == ST_OS_COM) && (arb_kind == OS_KIND_SKP);
    fts_clr    = take_arb && (arb_state == ST_OS_COM) && (arb_kind == OS_KIND_FTS);
    fts_pend_d = (fts_pend_q & ~fts_clr) | fts_req;
  end

  // Outputs decoded from state; only the underrun override looks at fifo_empty
  always_comb begin
    control     = CTL_OS;
    start_end   = SYM_STP;
    ordered_set = SYM_IDL;
    fifo_rd     = 1'b0;
    underrun    = 1'b0;
    pkt_done    = 1'b0;
    unique case (state_q)
      ST_OS_COM:    control = CTL_COM;
      ST_OS_BODY:   ordered_set = (kind_q == OS_KIND_FTS) ? SYM_FTS : SYM_SKP;
      ST_PKT_START: control = CTL_SE;
      ST_PKT_DATA: begin
        if (fifo_empty) begin
          control   = CTL_SE;
          start_end = SYM_EDB;
          underrun  = 1'b1;
        end else begin
          control = CTL_DATA;
          fifo_rd = 1'b1;
        end
      end
      ST_PKT_END: begin
        control   = CTL_SE;
        start_end = SYM_END;
        pkt_done  = 1'b1;
      end
      default: control = CTL_OS;
    endcase
  end

  assign logical_COM = SYM_COM;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// tb/tb_tx_frame_ctrl.sv - self-checking bench for tx_frame_ctrl against a symbol-plan reference model
module tb_tx_frame_ctrl;

  localparam int SKP_INTERVAL = 16;
  localparam int N_SKP        = 3;
  localparam int N_FTS        = 4;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_last = 1'b0;
  logic       fts_req = 1'b0;
  logic       fifo_rd;
  logic [1:0] control;
  logic [7:0] start_end;
  logic [7:0] ordered_set;
  logic [7:0] logical_COM;
  logic       underrun;
  logic       pkt_done;

  tx_frame_ctrl #(
    .SKP_INTERVAL(SKP_INTERVAL),
    .N_SKP       (N_SKP),
    .N_FTS       (N_FTS)
  ) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .fifo_empty (fifo_empty),
    .fifo_last  (fifo_last),
    .fts_req    (fts_req),
    .fifo_rd    (fifo_rd),
    .control    (control),
    .start_end  (start_end),
    .ordered_set(ordered_set),
    .logical_COM(logical_COM),
    .underrun   (underrun),
    .pkt_done   (pkt_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ctl;
    logic [7:0] se;
    logic [7:0] os;
    logic       rd;
    logic       un;
    logic       done;
  } sym_t;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  // upstream buffer contents
  logic [7:0] byte_q[$];
  logic       last_q[$];
  logic       stall = 1'b0;

  // reference model: a plan of fixed upcoming symbols plus a packet-in-flight flag
  sym_t plan[$];
  bit   pkt_active;
  int   m_cnt;
  bit   m_skp, m_fts;

  // per-cycle trace since the last reset, for the literal checks
  logic [1:0] tr_ctl[64];
  logic [7:0] tr_se[64];
  logic [7:0] tr_os[64];
  logic       tr_rd[64];
  logic       tr_un[64];
  logic       tr_done[64];

  logic [1:0] pkt4_ctl[8] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};

  function automatic sym_t mk(logic [1:0] c, logic [7:0] s, logic [7:0] o,
                              logic r, logic u, logic d);
    sym_t t;
    t.ctl = c; t.se = s; t.os = o; t.rd = r; t.un = u; t.done = d;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s (cycle %0d): got %h, required %h", name, cyc, act, exp);
  endtask

  task automatic push_bytes(int n, logic [7:0] base, bit last_at_end);
    for (int i = 0; i < n; i++) begin
      byte_q.push_back(base + 8'(i));
      last_q.push_back(last_at_end && (i == n - 1));
    end
  endtask

  task automatic drive_inputs();
    fifo_empty = stall || (byte_q.size() == 0);
    fifo_last  = (byte_q.size() != 0) ? last_q[0] : 1'b0;
  endtask

  task automatic arbitrate();
    if (m_skp) begin
      m_skp = 0;
      plan.push_back(mk(2'b11, 8'h00, 8'h00, 0, 0, 0));
      for (int i = 0; i < N_SKP; i++) plan.push_back(mk(2'b10, 8'h00, 8'h1C, 0, 0, 0));
    end else if (m_fts) begin
      m_fts = 0;
      plan.push_back(mk(2'b11, 8'h00, 8'h00, 0, 0, 0));
      for (int i = 0; i < N_FTS; i++) plan.push_back(mk(2'b10, 8'h00, 8'h3C, 0, 0, 0));
    end else if (!fifo_empty) begin
      plan.push_back(mk(2'b01, 8'hFB, 8'h00, 0, 0, 0));
      pkt_active = 1;
    end
  endtask

  // compare process: derive this cycle's symbol from the model, check the DUT, advance the model
  task automatic compare();
    sym_t cur;
    logic [28:0] act_v, exp_v;
    if (!reset_L) begin
      plan.delete();
      pkt_active = 0; m_cnt = 0; m_skp = 0; m_fts = 0;
      cyc = 0;
      return;
    end
    if (plan.size() != 0) begin
      cur = plan.pop_front();
    end else if (pkt_active) begin
      if (fifo_empty) begin
        cur = mk(2'b01, 8'hFE, 8'h00, 0, 1, 0);
        pkt_active = 0;
        plan.push_back(mk(2'b10, 8'h00, 8'h7C, 0, 0, 0));
      end else begin
        cur = mk(2'b00, 8'h00, 8'h00, 1, 0, 0);
        if (fifo_last) begin
          pkt_active = 0;
          plan.push_back(mk(2'b01, 8'hFD, 8'h00, 0, 0, 1));
        end
      end
    end else begin
      cur = mk(2'b10, 8'h00, 8'h7C, 0, 0, 0);
    end
    if (plan.size() == 0 && !pkt_active) arbitrate();
    if (m_cnt == SKP_INTERVAL - 1) begin
      m_cnt = 0;
      m_skp = 1;
    end else begin
      m_cnt++;
    end
    if (fts_req) m_fts = 1;

    act_v = {control, (control == 2'b01) ? start_end : 8'h00,
             (control == 2'b10) ? ordered_set : 8'h00, fifo_rd, underrun, pkt_done};
    exp_v = {cur.ctl, cur.se, cur.os, cur.rd, cur.un, cur.done};
    chk("model_outputs", {3'b0, act_v}, {3'b0, exp_v});
    if (logical_COM !== 8'hBC) chk("logical_com", {24'b0, logical_COM}, 32'hBC);

    if (cyc < 64) begin
      tr_ctl[cyc] = control; tr_se[cyc] = start_end; tr_os[cyc] = ordered_set;
      tr_rd[cyc] = fifo_rd; tr_un[cyc] = underrun; tr_done[cyc] = pkt_done;
    end
    if (cur.rd && byte_q.size() != 0) begin
      void'(byte_q.pop_front());
      void'(last_q.pop_front());
    end
    cyc++;
  endtask

  task automatic tick();
    drive_inputs();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    fts_req = 1'b0;
  endtask

  task automatic do_reset(bit clear);
    if (clear) begin
      byte_q.delete();
      last_q.delete();
    end
    stall   = 1'b0;
    fts_req = 1'b0;
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
  endtask

  task automatic chk_os(string name, int c, logic [7:0] os);
    chk({name, "_ctl"}, {30'b0, tr_ctl[c]}, 32'h2);
    chk({name, "_os"}, {24'b0, tr_os[c]}, {24'b0, os});
  endtask

  initial begin
    int n;
    plan.delete();
    pkt_active = 0; m_cnt = 0; m_skp = 0; m_fts = 0;

    // idle link after reset
    do_reset(1);
    repeat (10) tick();
    for (int i = 0; i < 10; i++) begin
      chk_os("idle", i, 8'h7C);
      chk("idle_rd", {31'b0, tr_rd[i]}, 32'h0);
    end

    // four-byte packet
    do_reset(1);
    push_bytes(4, 8'h01, 1);
    repeat (8) tick();
    for (int i = 0; i < 8; i++) chk("pkt4_ctl", {30'b0, tr_ctl[i]}, {30'b0, pkt4_ctl[i]});
    chk("pkt4_stp", {24'b0, tr_se[1]}, 32'hFB);
    chk("pkt4_end", {24'b0, tr_se[6]}, 32'hFD);
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(tr_rd[i]);
    chk("pkt4_rd_cycles", n, 4);
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(tr_done[i]);
    chk("pkt4_done_count", n, 1);
    chk("pkt4_done_at_end", {31'b0, tr_done[6]}, 32'h1);

    // SKP timer wraps inside an 8-byte packet
    do_reset(1);
    repeat (10) tick();
    push_bytes(8, 8'h10, 1);
    repeat (20) tick();
    chk("skp_pkt_stp", {24'b0, tr_se[11]}, 32'hFB);
    chk("skp_pkt_end", {22'b0, tr_ctl[20], tr_se[20]}, {22'b0, 2'b01, 8'hFD});
    chk("skp_pkt_com", {30'b0, tr_ctl[21]}, 32'h3);
    for (int i = 22; i < 25; i++) chk_os("skp_pkt_body", i, 8'h1C);
    chk_os("skp_pkt_after", 25, 8'h7C);

    // underrun after 2 of 5 bytes
    do_reset(1);
    push_bytes(2, 8'h20, 0);
    repeat (5) tick();
    chk("edb_ctl", {30'b0, tr_ctl[4]}, 32'h1);
    chk("edb_sym", {24'b0, tr_se[4]}, 32'hFE);
    chk("edb_underrun", {31'b0, tr_un[4]}, 32'h1);
    chk("edb_no_rd", {31'b0, tr_rd[4]}, 32'h0);
    push_bytes(3, 8'h22, 1);
    repeat (8) tick();
    chk_os("edb_idle", 5, 8'h7C);
    n = 0;
    for (int i = 0; i < 13; i++) n += int'(tr_un[i]);
    chk("edb_underrun_count", n, 1);

    // FTS request in the SKP wrap cycle
    do_reset(1);
    repeat (15) tick();
    fts_req = 1'b1;
    tick();
    repeat (12) tick();
    chk_os("both_pre", 16, 8'h7C);
    chk("both_com_skp", {30'b0, tr_ctl[17]}, 32'h3);
    for (int i = 18; i < 21; i++) chk_os("both_skp", i, 8'h1C);
    chk("both_com_fts", {30'b0, tr_ctl[21]}, 32'h3);
    for (int i = 22; i < 26; i++) chk_os("both_fts", i, 8'h3C);
    chk_os("both_after", 26, 8'h7C);

    // reset during data byte 3
    do_reset(1);
    push_bytes(5, 8'h30, 1);
    repeat (4) tick();
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    repeat (19) tick();
    chk_os("rst_idle", 0, 8'h7C);
    chk("rst_restart_stp", {22'b0, tr_ctl[1], tr_se[1]}, {22'b0, 2'b01, 8'hFB});
    chk("rst_end", {22'b0, tr_ctl[5], tr_se[5]}, {22'b0, 2'b01, 8'hFD});
    chk("rst_skp_restart", {30'b0, tr_ctl[17]}, 32'h3);

    // randomized traffic against the model
    do_reset(1);
    for (int k = 0; k < 4000; k++) begin
      if (byte_q.size() < 6 && $urandom_range(0, 5) == 0)
        push_bytes(int'($urandom_range(1, 8)), 8'($urandom), 1);
      if ($urandom_range(0, 9) == 0) stall = ~stall;
      if (stall && $urandom_range(0, 3) == 0) stall = 1'b0;
      fts_req = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 799) == 0) begin
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
